// File: rtl/msix_pkg.sv
// Shared types for the MSI-X interrupt arbiter.
// FSM states, vector-table entry layout and message constants.
package msix_pkg;

  localparam int MSIX_DW_BYTES   = 4;
  localparam int MSIX_MAX_ADDR_W = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_SEND
  } state_e;

  typedef struct packed {
    logic [MSIX_MAX_ADDR_W-1:0] addr;
    logic [31:0]                data;
    logic                       mask;
  } vec_entry_t;

endpackage

// File: rtl/msix_rr_arb.sv
// Round-robin pick of one requesting vector.
// Search starts at last_grant+1 and wraps to 0.
module msix_rr_arb #(
  parameter int NUM_VEC = 8
) (
  input  logic [NUM_VEC-1:0]         req,
  input  logic [$clog2(NUM_VEC)-1:0] last_grant,
  output logic [$clog2(NUM_VEC)-1:0] grant,
  output logic                       grant_vld
);

  localparam int IW = $clog2(NUM_VEC);

  int idx;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = NUM_VEC; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_VEC;
      if (req[idx]) begin
        grant     = IW'(idx);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/msix_intr_arb.sv
// MSI-X interrupt arbiter: pending/mask table, RR grant, DW write.
// Define MSIX_PBA_EN to expose the pending-bit array (pba/pba_clr).
module msix_intr_arb
  import msix_pkg::*;
#(
  parameter int NUM_VEC = 8,
  parameter int ADDR_W  = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_VEC-1:0]         intr_req,
  input  logic                       cfg_we,
  input  logic [$clog2(NUM_VEC)-1:0] cfg_idx,
  input  logic [ADDR_W-1:0]          cfg_addr,
  input  logic [31:0]                cfg_data,
  input  logic                       cfg_mask,
`ifdef MSIX_PBA_EN
  output logic [NUM_VEC-1:0]         pba,
  input  logic [NUM_VEC-1:0]         pba_clr,
`endif
  output logic                       wr_valid,
  input  logic                       wr_ready,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [31:0]                wr_data,
  output logic [$clog2(NUM_VEC)-1:0] wr_vec,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_VEC);

  vec_entry_t         tbl [NUM_VEC];
  logic [NUM_VEC-1:0] pending;
  logic [NUM_VEC-1:0] pend_nxt;
  logic [NUM_VEC-1:0] mask_v;
  logic [NUM_VEC-1:0] elig;
  state_e             state;
  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      grant;
  logic               grant_vld;
  logic               hs;
  vec_entry_t         ent;

  always_comb begin
    mask_v = '0;
    for (int i = 0; i < NUM_VEC; i++) begin
      mask_v[i] = tbl[i].mask;
    end
  end

  assign elig = pending & ~mask_v;
  assign hs   = (state == S_SEND) && wr_ready;
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VEC; i++) begin
        tbl[i] <= '{addr: '0, data: '0, mask: 1'b1};
      end
    end else if (cfg_we && (int'(cfg_idx) < NUM_VEC)) begin
      tbl[cfg_idx] <= '{addr: MSIX_MAX_ADDR_W'(cfg_addr),
                        data: cfg_data,
                        mask: cfg_mask};
    end
  end

  // A new pulse in the handshake cycle re-arms the vector.
  always_comb begin
    pend_nxt = pending;
    if (hs) begin
      pend_nxt[wr_vec] = 1'b0;
    end
`ifdef MSIX_PBA_EN
    pend_nxt = pend_nxt & ~(pba_clr & mask_v);
`endif
    pend_nxt = pend_nxt | intr_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pend_nxt;
    end
  end

`ifdef MSIX_PBA_EN
  assign pba = pending;
`endif

  msix_rr_arb #(
    .NUM_VEC(NUM_VEC)
  ) u_rr (
    .req       (elig),
    .last_grant(last_grant),
    .grant     (grant),
    .grant_vld (grant_vld)
  );

  // Same-cycle table write to the granted entry is forwarded.
  always_comb begin
    ent = tbl[grant];
    if (cfg_we && (cfg_idx == grant)) begin
      ent.addr = MSIX_MAX_ADDR_W'(cfg_addr);
      ent.data = cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= IW'(NUM_VEC - 1);
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_vec     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|elig) begin
            state <= S_ARB;
          end
        end
        S_ARB: begin
          if (grant_vld) begin
            wr_valid <= 1'b1;
            wr_addr  <= ADDR_W'(ent.addr);
            wr_data  <= ent.data;
            wr_vec   <= grant;
            state    <= S_SEND;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SEND: begin
          if (wr_ready) begin
            wr_valid   <= 1'b0;
            last_grant <= wr_vec;
            state      <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          wr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msix_intr_arb.sv
// Directed self-checking bench for msix_intr_arb.
// Default build (pba ports absent).
module tb_msix_intr_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  intr_req = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_idx = '0;
  logic [63:0] cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic        cfg_mask = 1'b1;
  logic        wr_valid;
  logic        wr_ready = 1'b0;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  wr_vec;
  logic        busy;

  int n_chk = 0;
  int n_pass = 0;
  int wr_cnt = 0;
  logic [2:0]  q_vec [$];
  logic [31:0] q_data [$];
  logic [63:0] q_addr [$];

  always #5 clk = ~clk;

  msix_intr_arb #(
    .NUM_VEC(8),
    .ADDR_W (64)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .intr_req(intr_req),
    .cfg_we  (cfg_we),
    .cfg_idx (cfg_idx),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .cfg_mask(cfg_mask),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_vec  (wr_vec),
    .busy    (busy)
  );

  // Inputs change only at posedge+1, so negedge sees the handshake.
  always @(negedge clk) begin
    if (rst_n && wr_valid && wr_ready) begin
      wr_cnt++;
      q_vec.push_back(wr_vec);
      q_data.push_back(wr_data);
      q_addr.push_back(wr_addr);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    intr_req = '0;
    cfg_we   = 1'b0;
    wr_ready = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
    wr_cnt = 0;
    q_vec.delete();
    q_data.delete();
    q_addr.delete();
  endtask

  task automatic cfg_wr(input logic [2:0] idx, input logic [63:0] a,
                        input logic [31:0] d, input logic m);
    cfg_we   = 1'b1;
    cfg_idx  = idx;
    cfg_addr = a;
    cfg_data = d;
    cfg_mask = m;
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] bits);
    intr_req = bits;
    step(1);
    intr_req = '0;
  endtask

  task automatic wait_wr(input int n, input int budget);
    int b;
    b = budget;
    while (wr_cnt < n && b > 0) begin
      step(1);
      b--;
    end
    if (wr_cnt < n) chk("wait_wr_timeout", 64'(wr_cnt), 64'(n));
  endtask

  task automatic wait_valid(input int budget);
    int b;
    b = budget;
    while (!wr_valid && b > 0) begin
      step(1);
      b--;
    end
    if (!wr_valid) chk("wait_valid_timeout", 64'(wr_valid), 64'd1);
  endtask

  initial begin
    do_reset();
    chk("rst_valid", 64'(wr_valid), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_addr",  wr_addr, 64'd0);
    chk("rst_data",  64'(wr_data), 64'd0);
    chk("rst_vec",   64'(wr_vec), 64'd0);

    // single vector, 3-cycle latency
    cfg_wr(3'd2, 64'hFEE0_0000, 32'h42, 1'b0);
    wr_ready = 1'b1;
    intr_req = 8'h04;
    step(1);
    intr_req = '0;
    step(1);
    chk("lat_c2_valid", 64'(wr_valid), 64'd0);
    step(1);
    chk("lat_c3_valid", 64'(wr_valid), 64'd1);
    chk("lat_addr", wr_addr, 64'hFEE0_0000);
    chk("lat_data", 64'(wr_data), 64'h42);
    chk("lat_vec",  64'(wr_vec), 64'd2);
    step(12);
    chk("lat_count", 64'(wr_cnt), 64'd1);
    chk("lat_idle", 64'(busy), 64'd0);

    // all vectors, round-robin order twice
    do_reset();
    for (int i = 0; i < 8; i++)
      cfg_wr(3'(i), 64'h1000 + 64'(i * 4), 32'(i) + 32'h100, 1'b0);
    wr_ready = 1'b1;
    pulse(8'hFF);
    wait_wr(8, 80);
    for (int i = 0; i < 8; i++)
      chk($sformatf("rr1_vec%0d", i), 64'(q_vec[i]), 64'(i));
    chk("rr1_data7", 64'(q_data[7]), 64'h107);
    pulse(8'hFF);
    wait_wr(16, 80);
    for (int i = 0; i < 8; i++)
      chk($sformatf("rr2_vec%0d", i), 64'(q_vec[8 + i]), 64'(i));
    chk("rr2_addr5", q_addr[13], 64'h1014);

    // masked vector waits for unmask
    do_reset();
    cfg_wr(3'd5, 64'h5000, 32'h55, 1'b1);
    wr_ready = 1'b1;
    pulse(8'h20);
    step(20);
    chk("mask_count", 64'(wr_cnt), 64'd0);
    chk("mask_busy", 64'(busy), 64'd0);
    cfg_wr(3'd5, 64'h5000, 32'h55, 1'b0);
    step(20);
    chk("unmask_count", 64'(wr_cnt), 64'd1);
    chk("unmask_vec", 64'(q_vec[0]), 64'd5);
    chk("unmask_data", 64'(q_data[0]), 64'h55);

    // reprogram during stalled SEND
    do_reset();
    cfg_wr(3'd3, 64'h3000, 32'h33, 1'b0);
    pulse(8'h08);
    wait_valid(10);
    cfg_wr(3'd3, 64'h3300, 32'h99, 1'b0);
    step(9);
    chk("stall_valid", 64'(wr_valid), 64'd1);
    chk("stall_data", 64'(wr_data), 64'h33);
    chk("stall_addr", wr_addr, 64'h3000);
    wr_ready = 1'b1;
    wait_wr(1, 10);
    chk("stall_sent", 64'(q_data[0]), 64'h33);
    pulse(8'h08);
    wait_wr(2, 20);
    chk("reprog_data", 64'(q_data[1]), 64'h99);
    chk("reprog_addr", q_addr[1], 64'h3300);

    // re-pulse in the handshake cycle
    do_reset();
    cfg_wr(3'd1, 64'h1100, 32'h11, 1'b0);
    pulse(8'h02);
    wait_valid(10);
    wr_ready = 1'b1;
    intr_req = 8'h02;
    step(1);
    intr_req = '0;
    step(20);
    chk("repulse_count", 64'(wr_cnt), 64'd2);
    chk("repulse_vec", 64'(q_vec[1]), 64'd1);

    // reset mid-SEND
    do_reset();
    cfg_wr(3'd4, 64'h4000, 32'h44, 1'b0);
    pulse(8'h10);
    wait_valid(10);
    rst_n = 1'b0;
    #1;
    chk("rstsend_valid", 64'(wr_valid), 64'd0);
    chk("rstsend_busy", 64'(busy), 64'd0);
    step(2);
    rst_n = 1'b1;
    wr_ready = 1'b1;
    step(20);
    chk("rstsend_pend", 64'(wr_cnt), 64'd0);
    pulse(8'h10);
    step(20);
    chk("rstsend_mask", 64'(wr_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
